// File: rtl/nonce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nonce_scheduler
// Description : Steps one miner core across a nonce range and compares each
//               double-SHA result against a 256-bit target.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_scheduler #(
    parameter int HASH_LE = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [607:0] header_prefix,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic [639:0] miner_block,
    output logic         miner_rst,
    input  logic [255:0] miner_hash,
    input  logic         miner_done,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         timeout_err,
    output logic [31:0]  golden_nonce,
    output logic [31:0]  cur_nonce
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    localparam logic [11:0] c_cnt_last = 12'(TIMEOUT - 1);

    state_t         r_state;
    logic [607:0]   r_prefix;
    logic [255:0]   r_target;
    logic [31:0]    r_end;
    logic [255:0]   r_hash;
    logic [11:0]    r_cnt;

    logic [255:0]   w_h;
    logic           w_hit;
    logic           w_last;

    generate
        if (HASH_LE != 0) begin : g_le
            for (genvar gi = 0; gi < 32; gi++) begin : g_hswap
                assign w_h[8*gi +: 8] = r_hash[8*(31-gi) +: 8];
            end
        end else begin : g_be
            assign w_h = r_hash;
        end
    endgenerate

    assign w_hit  = (w_h <= r_target);
    assign w_last = (cur_nonce == r_end);

    // Nonce sits little-endian in the last header word.
    assign miner_block = {r_prefix, cur_nonce[7:0], cur_nonce[15:8],
                          cur_nonce[23:16], cur_nonce[31:24]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prefix     <= '0;
            r_target     <= '0;
            r_end        <= '0;
            r_hash       <= '0;
            r_cnt        <= '0;
            miner_rst    <= 1'b1;
            busy         <= 1'b0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            timeout_err  <= 1'b0;
            golden_nonce <= '0;
            cur_nonce    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_prefix    <= header_prefix;
                        r_target    <= target;
                        r_end       <= nonce_end;
                        found       <= 1'b0;
                        timeout_err <= 1'b0;
                        if (nonce_start > nonce_end) begin
                            exhausted <= 1'b1;
                        end else begin
                            exhausted <= 1'b0;
                            cur_nonce <= nonce_start;
                            busy      <= 1'b1;
                            r_state   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        miner_rst <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 12'd1;
                    if (abort) begin
                        miner_rst <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (r_cnt == c_cnt_last) begin
                        timeout_err <= 1'b1;
                        miner_rst   <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (miner_done && (r_cnt != 12'd0)) begin
                        // First RUN cycle may still see done from the previous nonce.
                        r_hash    <= miner_hash;
                        miner_rst <= 1'b1;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_hit) begin
                        found        <= 1'b1;
                        golden_nonce <= cur_nonce;
                        busy         <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (w_last) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        cur_nonce <= cur_nonce + 32'd1;
                        r_state   <= S_LOAD;
                    end
                end
                default: begin
                    miner_rst <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nonce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonce_scheduler
// Description : Scoreboard bench for nonce_scheduler with a stub miner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonce_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [607:0] header_prefix;
    logic [255:0] target;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [639:0] miner_block;
    logic         miner_rst;
    logic [255:0] miner_hash;
    logic         miner_done;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic         timeout_err;
    logic [31:0]  golden_nonce;
    logic [31:0]  cur_nonce;

    nonce_scheduler #(.HASH_LE(1), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .header_prefix(header_prefix), .target(target),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
        .miner_block(miner_block), .miner_rst(miner_rst),
        .miner_hash(miner_hash), .miner_done(miner_done),
        .busy(busy), .found(found), .exhausted(exhausted),
        .timeout_err(timeout_err), .golden_nonce(golden_nonce),
        .cur_nonce(cur_nonce)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        found;
        logic        exh;
        logic        tmo;
        logic [31:0] golden;
        logic [31:0] cur;
        int          runs;
        int          busy_cyc;
        int          low_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Stub modes: 0 H=n^key, 1 H=all ones, 2 never done, 3 H={n^key,224'h0}
    int          stub_mode = 0;
    logic [31:0] stub_key  = '0;
    int          stub_cnt  = 0;
    logic        stub_done = 1'b0;
    logic [255:0] stub_hash = '0;

    assign miner_done = stub_done;
    assign miner_hash = stub_hash;

    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [255:0] swap256(input logic [255:0] v);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = v[8*(31-i) +: 8];
        return r;
    endfunction

    function automatic logic [255:0] ref_hash(input logic [31:0] n, input int mode,
                                               input logic [31:0] key);
        if (mode == 1) return '1;
        if (mode == 3) return {n ^ key, 224'h0};
        return {224'h0, n ^ key};
    endfunction

    // 10-cycle miner; done lingers until the next run's first cycle.
    always @(posedge clk) begin
        if (miner_rst) begin
            stub_cnt <= 0;
        end else begin
            if (stub_cnt == 0) stub_done <= 1'b0;
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == 9 && stub_mode != 2) begin
                stub_done <= 1'b1;
                stub_hash <= swap256(ref_hash(swap32(miner_block[31:0]), stub_mode, stub_key));
            end
        end
    end

    int   busy_cnt = 0;
    int   low_cnt  = 0;
    int   run_cnt  = 0;
    logic prev_mrst = 1'b1;

    always @(posedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (!miner_rst) low_cnt <= low_cnt + 1;
        if (prev_mrst && !miner_rst) run_cnt <= run_cnt + 1;
        prev_mrst <= miner_rst;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] s, input logic [31:0] e,
                                   input logic [255:0] tgt, input logic [31:0] key,
                                   input int mode);
        exp_t   x;
        longint n;
        x = '{found: 1'b0, exh: 1'b0, tmo: 1'b0, golden: '0, cur: s,
              runs: 0, busy_cyc: 0, low_cyc: 0};
        if (mode == 2) begin
            x.tmo = 1'b1; x.runs = 1; x.busy_cyc = 17; x.low_cyc = 16;
            return x;
        end
        n = longint'(s);
        while (1) begin
            x.runs++;
            if (ref_hash(n[31:0], mode, key) <= tgt) begin
                x.found = 1'b1; x.golden = n[31:0];
                break;
            end
            if (n == longint'(e) || x.runs > 64) begin
                x.exh = 1'b1;
                break;
            end
            n++;
        end
        x.cur      = n[31:0];
        x.busy_cyc = x.runs * 13;
        x.low_cyc  = x.runs * 11;
        return x;
    endfunction

    task automatic run_case(input string name, input logic [31:0] s, input logic [31:0] e,
                            input logic [255:0] tgt, input logic [31:0] key, input int mode);
        exp_t         x;
        int           b0, r0, l0, k;
        logic [607:0] hdr;
        for (int i = 0; i < 19; i++) hdr[32*i +: 32] = $urandom();
        stub_mode = mode;
        stub_key  = key;
        sb.push_back(model(s, e, tgt, key, mode));
        @(negedge clk);
        b0 = busy_cnt; r0 = run_cnt; l0 = low_cnt;
        header_prefix = hdr; target = tgt; nonce_start = s; nonce_end = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        header_prefix = '0; target = '1; nonce_start = 32'h0; nonce_end = 32'h0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (busy && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, ".idle"}, busy, 1'b0);
        x = sb.pop_front();
        check({name, ".found"}, found, x.found);
        check({name, ".exhausted"}, exhausted, x.exh);
        check({name, ".timeout"}, timeout_err, x.tmo);
        if (x.found) check({name, ".golden"}, golden_nonce, x.golden);
        check({name, ".cur_nonce"}, cur_nonce, x.cur);
        check({name, ".runs"}, run_cnt - r0, x.runs);
        check({name, ".busy_cycles"}, busy_cnt - b0, x.busy_cyc);
        check({name, ".run_cycles"}, low_cnt - l0, x.low_cyc);
        check({name, ".mrst_idle"}, miner_rst, 1'b1);
        check({name, ".blk_nonce"}, miner_block[31:0], swap32(x.cur));
        check({name, ".blk_prefix"}, miner_block[639:32], hdr);
    endtask

    initial begin
        int b0, r0, k;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        header_prefix = '0; target = '0; nonce_start = '0; nonce_end = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.miner_rst", miner_rst, 1'b1);
        check("rst.busy", busy, 1'b0);
        check("rst.flags", {found, exhausted, timeout_err}, 3'b000);
        check("rst.golden", golden_nonce, 32'h0);
        check("rst.cur", cur_nonce, 32'h0);
        check("rst.block", miner_block, 640'h0);
        @(negedge clk);
        rst = 1'b0;

        run_case("hit0", 32'd0, 32'd9, 256'd5, 32'h0, 0);
        run_case("range", 32'd10, 32'd12, {224'h0, 32'd7}, 32'h0, 0);
        run_case("equal", 32'd0, 32'd9, 256'd0, 32'd3, 0);
        run_case("genesis", 32'h7c2bac1b, 32'h7c2bac1f,
                 {32'h0, 32'hffff0000, 192'h0}, 32'h7c2bac1d, 3);
        check("genesis.blk", miner_block[31:0], 32'h1dac2b7c);
        run_case("top", 32'hffffffff, 32'hffffffff, 256'd7, 32'h0, 1);
        run_case("tmo", 32'd0, 32'd9, 256'd5, 32'h0, 2);

        // Inverted range: rejected in IDLE, clears the earlier timeout flag.
        @(negedge clk);
        b0 = busy_cnt; r0 = run_cnt;
        nonce_start = 32'd5; nonce_end = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        check("inv.exhausted", exhausted, 1'b1);
        check("inv.timeout", timeout_err, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("inv.busy_cycles", busy_cnt - b0, 0);
        check("inv.runs", run_cnt - r0, 0);

        // Abort during the third nonce.
        stub_mode = 0; stub_key = 32'h0;
        @(negedge clk);
        r0 = run_cnt;
        nonce_start = 32'd10; nonce_end = 32'd20; target = 256'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while ((run_cnt - r0) < 3 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check("abort.third_run", run_cnt - r0, 3);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        check("abort.busy", busy, 1'b0);
        check("abort.flags", {found, exhausted, timeout_err}, 3'b000);
        check("abort.mrst", miner_rst, 1'b1);
        @(negedge clk);
        abort = 1'b0;

        // Asynchronous reset between edges while running.
        nonce_start = 32'd0; nonce_end = 32'd9; target = 256'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (miner_rst && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("arst.running", miner_rst, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst.miner_rst", miner_rst, 1'b1);
        check("arst.busy", busy, 1'b0);
        check("arst.cur", cur_nonce, 32'h0);
        check("arst.block", miner_block, 640'h0);
        @(negedge clk);
        rst = 1'b0;
        run_case("after_rst", 32'd0, 32'd9, 256'd5, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
